// File: rtl/esp_cmd_link_if.sv
// esp_cmd_link_if: groups the CPU register-bus signals and the two byte
// streams that connect the command-link responder to its neighbours.
//   bus_addr    register select (0 = STATUS, 1 = DATA)
//   bus_wrdata  write data
//   bus_wren    one-cycle write strobe
//   bus_rden    one-cycle read strobe
//   bus_rddata  registered read data
//   tx_data     head of TX FIFO (bit 8 = start-of-message marker)
//   tx_valid    TX FIFO not empty
//   tx_ready    serializer accepts tx_data
//   rx_data     byte from ESP
//   rx_valid    one-cycle receive strobe, no backpressure
// The slave modport is the responder; master is the bus decoder/serializer side.
interface esp_cmd_link_if;
  logic        bus_addr;
  logic [31:0] bus_wrdata;
  logic        bus_wren;
  logic        bus_rden;
  logic [31:0] bus_rddata;
  logic [8:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  modport slave (
    input  bus_addr, bus_wrdata, bus_wren, bus_rden, tx_ready, rx_data, rx_valid,
    output bus_rddata, tx_data, tx_valid
  );

  modport master (
    output bus_addr, bus_wrdata, bus_wren, bus_rden, tx_ready, rx_data, rx_valid,
    input  bus_rddata, tx_data, tx_valid
  );
endinterface

// File: rtl/esp_cmd_link.sv
// esp_cmd_link: CPU-side responder for the ESP command channel.
// Two registers (STATUS, DATA) in front of a 9-bit TX FIFO feeding the
// serializer and an 8-bit RX FIFO filled by it.
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   link   esp_cmd_link_if.slave: register bus plus TX/RX byte streams
// STATUS: bit0 RX not empty, bit1 TX full, bit2 RX overflow (sticky),
//         bit3 TX empty. Writing bit0 flushes RX, bit2 clears overflow.
module esp_cmd_link #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  esp_cmd_link_if.slave        link
);

  localparam int TX_DEPTH = 2 ** TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 2 ** RX_DEPTH_LOG2;

  localparam logic [TX_DEPTH_LOG2:0]   TX_CNT_FULL = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
  localparam logic [RX_DEPTH_LOG2:0]   RX_CNT_FULL = {1'b1, {RX_DEPTH_LOG2{1'b0}}};
  localparam logic [TX_DEPTH_LOG2:0]   TX_CNT_ONE  = (TX_DEPTH_LOG2+1)'(1'b1);
  localparam logic [RX_DEPTH_LOG2:0]   RX_CNT_ONE  = (RX_DEPTH_LOG2+1)'(1'b1);
  localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE  = TX_DEPTH_LOG2'(1'b1);
  localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE  = RX_DEPTH_LOG2'(1'b1);

  logic [8:0]               tx_mem_r [TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr_r;
  logic [TX_DEPTH_LOG2-1:0] tx_rd_ptr_r;
  logic [TX_DEPTH_LOG2:0]   tx_count_r;

  logic [7:0]               rx_mem_r [RX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr_r;
  logic [RX_DEPTH_LOG2-1:0] rx_rd_ptr_r;
  logic [RX_DEPTH_LOG2:0]   rx_count_r;

  logic                     ovf_r;
  logic [31:0]              rddata_r;

  logic        tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic        wr_data_s, wr_stat_s, rd_data_s, rd_stat_s;
  logic        tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, rx_flush_s;
  logic        ovf_set_s, ovf_clr_s;
  logic [31:0] status_s;

  // Decode strobes and FIFO events; a write masks any simultaneous read.
  always_comb begin
    tx_full_s  = (tx_count_r == TX_CNT_FULL);
    tx_empty_s = (tx_count_r == '0);
    rx_full_s  = (rx_count_r == RX_CNT_FULL);
    rx_empty_s = (rx_count_r == '0);

    wr_data_s  = link.bus_wren & link.bus_addr;
    wr_stat_s  = link.bus_wren & ~link.bus_addr;
    rd_data_s  = link.bus_rden & ~link.bus_wren & link.bus_addr;
    rd_stat_s  = link.bus_rden & ~link.bus_wren & ~link.bus_addr;

    tx_pop_s   = ~tx_empty_s & link.tx_ready;
    // A full FIFO still takes a push when the serializer frees a slot this cycle.
    tx_push_s  = wr_data_s & (~tx_full_s | tx_pop_s);

    rx_flush_s = wr_stat_s & link.bus_wrdata[0];
    rx_pop_s   = rd_data_s & ~rx_empty_s;
    // Flush discards the arriving byte and suppresses any overflow it would cause.
    rx_push_s  = link.rx_valid & ~rx_flush_s & (~rx_full_s | rx_pop_s);
    ovf_set_s  = link.rx_valid & ~rx_flush_s & rx_full_s & ~rx_pop_s;
    ovf_clr_s  = wr_stat_s & link.bus_wrdata[2];

    status_s   = {28'd0, tx_empty_s, ovf_r, tx_full_s, ~rx_empty_s};
  end

  // FIFO storage arrays; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (tx_push_s) begin
      tx_mem_r[tx_wr_ptr_r] <= link.bus_wrdata[8:0];
    end
    if (rx_push_s) begin
      rx_mem_r[rx_wr_ptr_r] <= link.rx_data;
    end
  end

  // TX pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr_r <= '0;
      tx_rd_ptr_r <= '0;
      tx_count_r  <= '0;
    end else begin
      if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + TX_PTR_ONE;
      if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + TX_PTR_ONE;
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_count_r <= tx_count_r + TX_CNT_ONE;
        2'b01:   tx_count_r <= tx_count_r - TX_CNT_ONE;
        default: tx_count_r <= tx_count_r;
      endcase
    end
  end

  // RX pointers, occupancy and flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr_ptr_r <= '0;
      rx_rd_ptr_r <= '0;
      rx_count_r  <= '0;
    end else if (rx_flush_s) begin
      rx_wr_ptr_r <= '0;
      rx_rd_ptr_r <= '0;
      rx_count_r  <= '0;
    end else begin
      if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + RX_PTR_ONE;
      if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + RX_PTR_ONE;
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_count_r <= rx_count_r + RX_CNT_ONE;
        2'b01:   rx_count_r <= rx_count_r - RX_CNT_ONE;
        default: rx_count_r <= rx_count_r;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Read data register; holds between read strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rddata_r <= 32'd0;
    end else if (rd_stat_s) begin
      rddata_r <= status_s;
    end else if (rd_data_s) begin
      rddata_r <= rx_empty_s ? 32'd0 : {24'd0, rx_mem_r[rx_rd_ptr_r]};
    end else begin
      rddata_r <= rddata_r;
    end
  end

  assign link.bus_rddata = rddata_r;
  assign link.tx_data    = tx_mem_r[tx_rd_ptr_r];
  assign link.tx_valid   = ~tx_empty_s;

endmodule

// File: tb/tb_esp_cmd_link.sv
// tb_esp_cmd_link: self-checking bench for esp_cmd_link.
// Every cycle is driven through tick(), which also advances a queue-based
// reference model and compares tx_valid/tx_data/bus_rddata against it.
// A vector table, hand-written corner sequences and a random phase follow.
module tb_esp_cmd_link;

  localparam int TXD = 16;
  localparam int RXD = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  esp_cmd_link_if link();

  esp_cmd_link #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
    .clk   (clk),
    .reset (reset),
    .link  (link)
  );

  // reference model state
  logic [8:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  logic        m_ovf;
  logic [31:0] m_rd;

  int total = 0;
  int bad   = 0;
  logic ready_level = 1'b0;

  typedef struct {
    logic        wren, rden, addr;
    logic [31:0] wrdata;
    logic        tx_ready, rx_valid;
    logic [7:0]  rx_byte;
    logic [31:0] exp_rd;
    logic        exp_txv;
    logic [8:0]  exp_txd;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_ovf = 1'b0;
    m_rd  = 32'd0;
  endtask

  // One clock cycle: called at a falling edge, returns at the next one.
  task automatic tick(input logic wren, input logic rden, input logic addr,
                      input logic [31:0] wrdata, input logic tx_ready,
                      input logic rx_valid, input logic [7:0] rx_byte);
    logic [31:0] status;
    logic        sel_stat;
    link.bus_wren   = wren;
    link.bus_rden   = rden;
    link.bus_addr   = addr;
    link.bus_wrdata = wrdata;
    link.tx_ready   = tx_ready;
    link.rx_valid   = rx_valid;
    link.rx_data    = rx_byte;
    sel_stat = wren && !addr;
    status = {28'd0, m_tx.size() == 0, m_ovf, m_tx.size() == TXD, m_rx.size() != 0};
    if (rden && !wren) begin
      if (!addr)                m_rd = status;
      else if (m_rx.size() == 0) m_rd = 32'd0;
      else                       m_rd = {24'd0, m_rx.pop_front()};
    end
    if (tx_ready && m_tx.size() != 0) void'(m_tx.pop_front());
    if (wren && addr && m_tx.size() < TXD) m_tx.push_back(wrdata[8:0]);
    if (sel_stat && wrdata[2]) m_ovf = 1'b0;
    if (sel_stat && wrdata[0]) m_rx.delete();
    else if (rx_valid) begin
      if (m_rx.size() < RXD) m_rx.push_back(rx_byte);
      else                   m_ovf = 1'b1;
    end
    @(negedge clk);
    check("model_tx_valid", link.tx_valid, m_tx.size() != 0);
    if (m_tx.size() != 0) check("model_tx_data", link.tx_data, m_tx[0]);
    check("model_rddata", link.bus_rddata, m_rd);
  endtask

  task automatic wr(input logic addr, input logic [31:0] data);
    tick(1'b1, 1'b0, addr, data, ready_level, 1'b0, 8'h00);
  endtask

  task automatic rd_expect(input string name, input logic addr, input logic [31:0] exp);
    tick(1'b0, 1'b1, addr, 32'd0, ready_level, 1'b0, 8'h00);
    check(name, link.bus_rddata, exp);
  endtask

  task automatic rxin(input logic [7:0] b);
    tick(1'b0, 1'b0, 1'b0, 32'd0, ready_level, 1'b1, b);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_tx_valid", link.tx_valid, 1'b0);
    check("reset_rddata", link.bus_rddata, 32'd0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] exp_tx[16];
    int n;
    reset = 1'b1;
    link.bus_wren = 1'b0; link.bus_rden = 1'b0; link.bus_addr = 1'b0;
    link.bus_wrdata = 32'd0; link.tx_ready = 1'b0;
    link.rx_valid = 1'b0; link.rx_data = 8'h00;
    model_reset();
    @(negedge clk);
    do_reset();

    // wren rden addr wrdata tx_ready rx_valid rx_byte | exp_rd exp_txv exp_txd
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 32'h8,  1'b0, 9'h000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 9'h000};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 9'h100};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h010, 1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 9'h100};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h02F, 1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 9'h100};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h000, 1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 9'h100};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 9'h100};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 8'h00, 32'h0,  1'b1, 9'h010};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 8'h00, 32'h0,  1'b1, 9'h02F};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 8'h00, 32'h0,  1'b1, 9'h000};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 8'h00, 32'h0,  1'b0, 9'h000};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 8'h00, 32'h8,  1'b0, 9'h000};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 8'h00, 32'h8,  1'b0, 9'h000};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 8'h34, 32'h8,  1'b0, 9'h000};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 8'h12, 32'h8,  1'b0, 9'h000};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 32'h9,  1'b0, 9'h000};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 8'h00, 32'h00, 1'b0, 9'h000};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 8'h00, 32'h34, 1'b0, 9'h000};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 8'h00, 32'h12, 1'b0, 9'h000};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 32'h8,  1'b0, 9'h000};

    for (int i = 0; i < 20; i++) begin
      tick(vecs[i].wren, vecs[i].rden, vecs[i].addr, vecs[i].wrdata,
           vecs[i].tx_ready, vecs[i].rx_valid, vecs[i].rx_byte);
      check($sformatf("vec%0d_rddata", i), link.bus_rddata, vecs[i].exp_rd);
      check($sformatf("vec%0d_tx_valid", i), link.tx_valid, vecs[i].exp_txv);
      if (vecs[i].exp_txv) check($sformatf("vec%0d_tx_data", i), link.tx_data, vecs[i].exp_txd);
    end

    // TX overfill: 17 writes into a 16-deep FIFO, last one dropped.
    ready_level = 1'b0;
    for (int i = 0; i < 17; i++) begin
      logic [8:0] v;
      v = (i == 0) ? 9'h100 : 9'(i * 5 + 3);
      if (i < 16) exp_tx[i] = v;
      wr(1'b1, {23'd0, v});
      if (i == 14) rd_expect("txfill_15_status", 1'b0, 32'h0);
      if (i == 15) rd_expect("txfill_16_status", 1'b0, 32'h2);
    end
    rd_expect("txfill_17_status", 1'b0, 32'h2);
    n = 0;
    for (int c = 0; c < 40 && link.tx_valid; c++) begin
      if (n < 16) check($sformatf("txdrain_%0d", n), link.tx_data, exp_tx[n]);
      n++;
      tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 8'h00);
    end
    check("txdrain_count", n, 16);

    // RX overflow: 17 bytes, no reads.
    for (int i = 0; i < 17; i++) rxin(8'(8'h80 + i));
    rd_expect("rxovf_status", 1'b0, 32'hD);
    for (int i = 0; i < 16; i++) rd_expect($sformatf("rxovf_rd%0d", i), 1'b1, 32'(8'h80 + i));
    rd_expect("rxovf_drained_status", 1'b0, 32'hC);
    wr(1'b0, 32'h4);
    rd_expect("rxovf_cleared_status", 1'b0, 32'h8);

    // RX full with simultaneous push and CPU pop, then flush racing rx_valid.
    for (int i = 0; i < 16; i++) rxin(8'(8'h40 + i));
    tick(1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1, 8'hEE);
    check("rxfull_poppush_rd", link.bus_rddata, 32'h40);
    rd_expect("rxfull_poppush_status", 1'b0, 32'h9);
    tick(1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 1'b1, 8'h55);
    rd_expect("flush_status", 1'b0, 32'h8);
    rd_expect("flush_data_rd", 1'b1, 32'h0);

    // Overflow set beats a same-cycle clear.
    for (int i = 0; i < 16; i++) rxin(8'(i));
    tick(1'b1, 1'b0, 1'b0, 32'h4, 1'b0, 1'b1, 8'h77);
    rd_expect("ovf_set_wins_status", 1'b0, 32'hD);
    wr(1'b0, 32'h5);

    // Write has priority over a simultaneous read; bus_rddata holds.
    tick(1'b1, 1'b1, 1'b1, 32'hFFFF_F1AB, 1'b0, 1'b0, 8'h00);
    check("wr_prio_rddata", link.bus_rddata, 32'hD);
    check("wr_prio_tx_data", link.tx_data, 9'h1AB);

    // Random phase against the model, with a mid-run asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      int op;
      logic wren, rden, addr, txr;
      op = $urandom_range(0, 9);
      wren = (op <= 3) || (op == 9);
      rden = (op == 4) || (op == 5) || (op == 9);
      addr = (op <= 2) || (op == 5) || (op == 9);
      txr  = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      tick(wren, rden, addr, $urandom, txr, $urandom_range(0, 2) == 0, 8'($urandom));
      if (i == 1700) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
